// File: rtl/bist_response_analyzer_if.sv
// BIST response analyzer bus.
// Carries the controller inputs, the CUT response and the result pins.
interface bist_response_analyzer_if #(
  parameter int W = 8
);
  logic         START;
  logic         EN;
  logic         FINISH;
  logic [W-1:0] DATA_IN;
  logic [W-1:0] SIGNATURE;
  logic         BUSY;
  logic         DONE;
  logic         PASS;
  logic         FAIL;

  modport master (
    output START, EN, FINISH, DATA_IN,
    input  SIGNATURE, BUSY, DONE, PASS, FAIL
  );

  modport slave (
    input  START, EN, FINISH, DATA_IN,
    output SIGNATURE, BUSY, DONE, PASS, FAIL
  );
endinterface

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer.
// Compacts CUT responses in a Galois MISR and checks signature and count.
module bist_response_analyzer #(
  parameter int           W         = 8,
  parameter logic [W-1:0] POLY      = W'(8'h1D),
  parameter logic [W-1:0] SEED_VAL  = '0,
  parameter logic [W-1:0] GOLDEN    = '0,
  parameter int           EXP_COUNT = 990,
  parameter int           CW        = 11
) (
  input  logic                     CLK,
  input  logic                     RESET,
  bist_response_analyzer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    DONE_S  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  misr_q, misr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;

  logic          rise;
  logic          match;
  logic [W-1:0]  misr_nxt;

  assign rise  = bus.START & ~start_q;
  assign match = (misr_q == GOLDEN) && (cnt_q == CW'(EXP_COUNT));

  // Galois step: shift up, fold the MSB back through the taps, add response.
  assign misr_nxt = {misr_q[W-2:0], 1'b0}
                  ^ ({W{misr_q[W-1]}} & POLY)
                  ^ bus.DATA_IN;

  // Registered state, signature, counter, result flags and START history.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      misr_q  <= SEED_VAL;
      cnt_q   <= '0;
      start_q <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      start_q <= bus.START;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state, capture and compare decisions.
  always_comb begin
    state_d = state_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE_S: begin
        if (rise) begin
          misr_d  = SEED_VAL;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.EN) begin
          misr_d = misr_nxt;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        if (bus.FINISH) state_d = COMPARE;
      end
      COMPARE: begin
        pass_d  = match;
        fail_d  = ~match;
        done_d  = 1'b1;
        state_d = DONE_S;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.SIGNATURE = misr_q;
  assign bus.BUSY      = (state_q == CAPTURE) || (state_q == COMPARE);
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.FAIL      = fail_q;

endmodule
